// File: rtl/jtag_tap_host.sv
// Host-side JTAG initiator: sequences TCK/TMS/TDI for IR/DR scans, TAP reset and
// run-idle commands, and returns the TDO bits captured while shifting.
module jtag_tap_host #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               tl_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  // state   | meaning
  // RST_SEQ | 6 TCKs, TMS=1,1,1,1,1,0: any TAP state -> Run-Test/Idle
  // IDLE    | tck low, ready for a command (or flagging completion)
  // PRE     | walk from Run-Test/Idle to Shift-IR/DR (Capture only when len==0)
  // SHIFT   | len TCKs moving data out on tdi and tdo into rsp_data
  // POST    | Exit1 -> Update -> Run-Test/Idle
  // RUNI    | len TCKs with TMS=0

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [2:0] {RST_SEQ, IDLE, PRE, SHIFT, POST, RUNI} state_t;

  state_t             state, state_nx;
  logic               ph, ph_nx;           // 0: next edge drives low phase, 1: next edge raises tck
  logic [LEN_W-1:0]   cnt, cnt_nx;         // TCKs left in the current state, minus one
  logic [LEN_W-1:0]   len_q, len_nx;
  logic [MAX_LEN-1:0] data_sr, data_sr_nx;
  logic [MAX_LEN-1:0] mask, mask_nx;
  logic [MAX_LEN-1:0] rsp_data_nx;
  logic               fin, fin_nx;         // last TCK done, tck falls and we report next edge
  logic               fin_rsp, fin_rsp_nx; // completion belongs to a command (not power-up)
  logic               tck_nx, tms_nx, tdi_nx, rsp_valid_nx;
  logic               tms_cur;
  logic [LEN_W-1:0]   len_cl;

  assign len_cl    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign cmd_ready = (state == IDLE) && !fin;

  // With len==0 the last PRE TCK heads to Exit1 instead of Shift.
  always_comb begin
    tms_cur = 1'b0;
    case (state)
      RST_SEQ: tms_cur = (cnt != '0);
      PRE:     tms_cur = (cnt == '0) ? (len_q == '0) : (cnt >= LEN_W'(2));
      SHIFT:   tms_cur = (cnt == '0);
      POST:    tms_cur = (cnt == LEN_W'(1));
      default: tms_cur = 1'b0;
    endcase
  end

  always_comb begin
    state_nx     = state;
    ph_nx        = ph;
    cnt_nx       = cnt;
    len_nx       = len_q;
    data_sr_nx   = data_sr;
    mask_nx      = mask;
    fin_nx       = fin;
    fin_rsp_nx   = fin_rsp;
    tck_nx       = tck;
    tms_nx       = tms;
    tdi_nx       = tdi;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = rsp_data;
    case (state)
      IDLE: begin
        tck_nx = 1'b0;
        tms_nx = 1'b0;
        tdi_nx = 1'b0;
        if (fin) begin
          fin_nx       = 1'b0;
          rsp_valid_nx = fin_rsp;
        end else if (cmd_valid) begin
          len_nx      = len_cl;
          data_sr_nx  = cmd_data;
          mask_nx     = MAX_LEN'(1);
          rsp_data_nx = '0;
          ph_nx       = 1'b0;
          fin_rsp_nx  = 1'b1;
          case (cmd_op)
            OP_RESET: begin
              state_nx = RST_SEQ;
              cnt_nx   = LEN_W'(5);
            end
            OP_IR: begin
              state_nx = PRE;
              cnt_nx   = LEN_W'(3);
            end
            OP_DR: begin
              state_nx = PRE;
              cnt_nx   = LEN_W'(2);
            end
            default: begin
              if (len_cl == '0) begin
                fin_nx = 1'b1;
              end else begin
                state_nx = RUNI;
                cnt_nx   = len_cl - LEN_W'(1);
              end
            end
          endcase
        end
      end
      default: begin
        if (!ph) begin
          tck_nx = 1'b0;
          tms_nx = tms_cur;
          tdi_nx = (state == SHIFT) && data_sr[0];
          ph_nx  = 1'b1;
        end else begin
          tck_nx = 1'b1;
          ph_nx  = 1'b0;
          cnt_nx = cnt - LEN_W'(1);
          if (state == SHIFT) begin
            if (tdo) rsp_data_nx = rsp_data | mask;
            mask_nx    = {mask[MAX_LEN-2:0], 1'b0};
            data_sr_nx = {1'b0, data_sr[MAX_LEN-1:1]};
          end
          if (cnt == '0) begin
            case (state)
              PRE: begin
                if (len_q == '0) begin
                  state_nx = POST;
                  cnt_nx   = LEN_W'(1);
                end else begin
                  state_nx = SHIFT;
                  cnt_nx   = len_q - LEN_W'(1);
                end
              end
              SHIFT: begin
                state_nx = POST;
                cnt_nx   = LEN_W'(1);
              end
              default: begin
                state_nx = IDLE;
                fin_nx   = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge tl_reset) begin
    if (!tl_reset) begin
      state     <= RST_SEQ;
      ph        <= 1'b0;
      cnt       <= LEN_W'(5);
      len_q     <= '0;
      data_sr   <= '0;
      mask      <= '0;
      fin       <= 1'b0;
      fin_rsp   <= 1'b0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      ph        <= ph_nx;
      cnt       <= cnt_nx;
      len_q     <= len_nx;
      data_sr   <= data_sr_nx;
      mask      <= mask_nx;
      fin       <= fin_nx;
      fin_rsp   <= fin_rsp_nx;
      tck       <= tck_nx;
      tms       <= tms_nx;
      tdi       <= tdi_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
    end
  end

endmodule
